// File: rtl/sr_pipe_ctrl_pkg.sv
// Shared types for the schoolRISCV pipeline sequencing controller.
// State encoding is fixed so that debug probes of the state register stay stable.
package sr_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        BR_WAIT  = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic reg_hazard(input logic use_f, input logic [4:0] r, input logic busy_f);
        return use_f && (r != 5'd0) && busy_f;
    endfunction

endpackage

// File: rtl/sr_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set on issue, cleared on retire.
// Reads see only registered state, so a retiring register still reads busy in its retire cycle.
module sr_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_vld,
    input  logic [4:0]  set_rd,
    input  logic        clr_vld,
    input  logic [4:0]  clr_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_busy,
    output logic [31:0] busy_o
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_vld) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_vld && (set_rd != 5'd0)) begin
            busy_d[set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];
    assign rd_busy  = busy_q[rd];
    assign busy_o   = busy_q;

endmodule

// File: rtl/sr_pipe_ctrl.sv
// Decides issue from decode into execute, freezes fetch across unresolved branches, drives next PC.
// Issue is combinational from decode; branches cost BR_WAIT cycles plus one REDIRECT cycle.
module sr_pipe_ctrl
    import sr_pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          MAX_INFLIGHT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_valid,
    input  logic [4:0]  d_rs1,
    input  logic [4:0]  d_rs2,
    input  logic        d_rs1_use,
    input  logic        d_rs2_use,
    input  logic [4:0]  d_rd,
    input  logic        d_regWrite,
    input  logic        d_branch,
    input  logic [31:0] pc_plus4,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regWrite,
    input  logic        br_resolved,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        issue,
    output logic        stall_fd,
    output logic        bubble_de,
    output logic        pc_we,
    output logic [31:0] pc_next,
    output logic [31:0] busy_o,
    output logic [2:0]  inflight_o,
    output logic        err_o
);

    localparam logic [2:0] MAX_IF = MAX_INFLIGHT[2:0];

    state_t      state_q, state_d;
    logic [2:0]  inflight_q, inflight_d;
    logic [31:0] saved_pc_q, saved_pc_d;
    logic        err_q, err_d;

    logic rs1_busy, rs2_busy, rd_busy;
    logic hazard, can_issue, wb_ok;

    sr_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_vld  (issue && d_regWrite),
        .set_rd   (d_rd),
        .clr_vld  (wb_valid && wb_regWrite),
        .clr_rd   (wb_rd),
        .rs1      (d_rs1),
        .rs2      (d_rs2),
        .rd       (d_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .busy_o   (busy_o)
    );

    assign hazard = reg_hazard(d_rs1_use, d_rs1, rs1_busy)
                 || reg_hazard(d_rs2_use, d_rs2, rs2_busy)
                 || reg_hazard(d_regWrite, d_rd, rd_busy);

    assign can_issue = (state_q == RUN) && d_valid && !hazard && (inflight_q < MAX_IF);

    always_comb begin
        state_d    = state_q;
        saved_pc_d = saved_pc_q;
        issue      = 1'b0;
        stall_fd   = 1'b1;
        bubble_de  = 1'b1;
        pc_we      = 1'b0;
        pc_next    = pc_plus4;
        case (state_q)
            BOOT: begin
                pc_we   = 1'b1;
                pc_next = RESET_PC;
                state_d = RUN;
            end
            RUN: begin
                issue     = can_issue;
                stall_fd  = d_valid && !can_issue;
                bubble_de = !can_issue;
                pc_we     = !(d_valid && !can_issue);
                if (can_issue && d_branch) begin
                    saved_pc_d = pc_plus4;
                    state_d    = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (br_resolved) begin
                    if (br_taken) begin
                        saved_pc_d = br_target;
                    end
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                pc_we    = 1'b1;
                pc_next  = saved_pc_q;
                stall_fd = 1'b0;
                state_d  = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    // A retire with nothing in flight is a protocol error and must not underflow the count.
    always_comb begin
        wb_ok      = wb_valid && (inflight_q != 3'd0);
        err_d      = err_q;
        if (wb_valid && (inflight_q == 3'd0)) begin
            err_d = 1'b1;
        end
        if (br_resolved && (state_q != BR_WAIT)) begin
            err_d = 1'b1;
        end
        inflight_d = inflight_q + {2'b00, issue} - {2'b00, wb_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            inflight_q <= 3'd0;
            saved_pc_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            saved_pc_q <= saved_pc_d;
            err_q      <= err_d;
        end
    end

    assign inflight_o = inflight_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_sr_pipe_ctrl.sv
// Cycle-by-cycle vector table for sr_pipe_ctrl, followed by a mid-branch asynchronous reset sequence.
module tb_sr_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        d_valid = 1'b0;
    logic [4:0]  d_rs1 = '0, d_rs2 = '0, d_rd = '0, wb_rd = '0;
    logic        d_rs1_use = 1'b0, d_rs2_use = 1'b0, d_regWrite = 1'b0, d_branch = 1'b0;
    logic [31:0] pc_plus4 = 32'h100, br_target = '0;
    logic        wb_valid = 1'b0, wb_regWrite = 1'b0, br_resolved = 1'b0, br_taken = 1'b0;
    logic        issue, stall_fd, bubble_de, pc_we, err_o;
    logic [31:0] pc_next, busy_o;
    logic [2:0]  inflight_o;

    always #5 clk = ~clk;

    sr_pipe_ctrl #(.RESET_PC(32'h0), .MAX_INFLIGHT(3)) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rs1_use(d_rs1_use), .d_rs2_use(d_rs2_use), .d_rd(d_rd), .d_regWrite(d_regWrite),
        .d_branch(d_branch), .pc_plus4(pc_plus4), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_regWrite(wb_regWrite), .br_resolved(br_resolved), .br_taken(br_taken),
        .br_target(br_target), .issue(issue), .stall_fd(stall_fd), .bubble_de(bubble_de),
        .pc_we(pc_we), .pc_next(pc_next), .busy_o(busy_o), .inflight_o(inflight_o), .err_o(err_o)
    );

    typedef struct {
        logic rst; logic dv; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic [4:0] rd; logic rw; logic br; logic [31:0] pc4;
        logic wv; logic [4:0] wrd; logic wrw; logic brr; logic brt; logic [31:0] tgt;
        logic [3:0] isbw; logic chkpc; logic [31:0] npc; logic [2:0] f; logic [31:0] busy; logic e;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input logic rst, input logic dv, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
        input logic u2, input logic [4:0] rd, input logic rw, input logic br, input logic [31:0] pc4,
        input logic wv, input logic [4:0] wrd, input logic wrw, input logic brr, input logic brt,
        input logic [31:0] tgt, input logic [3:0] isbw, input logic chkpc, input logic [31:0] npc,
        input logic [2:0] f, input logic [31:0] busy, input logic e);
        vec_t v;
        v.rst = rst; v.dv = dv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.rw = rw;
        v.br = br; v.pc4 = pc4; v.wv = wv; v.wrd = wrd; v.wrw = wrw; v.brr = brr; v.brt = brt;
        v.tgt = tgt; v.isbw = isbw; v.chkpc = chkpc; v.npc = npc; v.f = f; v.busy = busy; v.e = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst; d_valid = v.dv; d_rs1 = v.rs1; d_rs1_use = v.u1; d_rs2 = v.rs2; d_rs2_use = v.u2;
        d_rd = v.rd; d_regWrite = v.rw; d_branch = v.br; pc_plus4 = v.pc4;
        wb_valid = v.wv; wb_rd = v.wrd; wb_regWrite = v.wrw;
        br_resolved = v.brr; br_taken = v.brt; br_target = v.tgt;
    endtask

    initial begin
        vec_t e;
        // rst dv rs1 u1 rs2 u2 rd rw br pc4 | wv wrd wrw | brr brt tgt | isbw chk npc f busy err
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h100, 0,0,0, 0,0,0, 4'b0111,1,32'h0,  0,32'h00,0)); // in reset
        tbl.push_back(mk(1,1,0,0,0,0,5,1,0,32'h104, 0,0,0, 0,0,0, 4'b0111,1,32'h0,  0,32'h00,0)); // BOOT
        tbl.push_back(mk(1,1,0,0,0,0,5,1,0,32'h104, 0,0,0, 0,0,0, 4'b1001,1,32'h104,0,32'h00,0)); // add x5
        tbl.push_back(mk(1,1,5,1,0,0,6,1,0,32'h108, 0,0,0, 0,0,0, 4'b0110,1,32'h108,1,32'h20,0)); // RAW on x5
        tbl.push_back(mk(1,1,5,1,0,0,6,1,0,32'h108, 1,5,1, 0,0,0, 4'b0110,1,32'h108,1,32'h20,0)); // retire, no bypass
        tbl.push_back(mk(1,1,5,1,0,0,6,1,0,32'h108, 0,0,0, 0,0,0, 4'b1001,1,32'h108,0,32'h00,0)); // N+1 issues
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,32'h10c, 1,6,1, 0,0,0, 4'b0011,1,32'h10c,1,32'h40,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,1,0,32'h110, 0,0,0, 0,0,0, 4'b1001,1,32'h110,0,32'h00,0));
        tbl.push_back(mk(1,1,0,0,0,0,2,1,0,32'h114, 0,0,0, 0,0,0, 4'b1001,1,32'h114,1,32'h02,0));
        tbl.push_back(mk(1,1,0,0,0,0,3,1,0,32'h118, 0,0,0, 0,0,0, 4'b1001,1,32'h118,2,32'h06,0));
        tbl.push_back(mk(1,1,0,0,0,0,4,1,0,32'h11c, 0,0,0, 0,0,0, 4'b0110,1,32'h11c,3,32'h0e,0)); // limit
        tbl.push_back(mk(1,1,0,0,0,0,4,1,0,32'h11c, 1,1,1, 0,0,0, 4'b0110,1,32'h11c,3,32'h0e,0));
        tbl.push_back(mk(1,1,0,0,0,0,4,1,0,32'h11c, 1,3,1, 0,0,0, 4'b1001,1,32'h11c,2,32'h0c,0)); // issue+retire
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,32'h120, 0,0,0, 0,0,0, 4'b0011,1,32'h120,2,32'h14,0));
        tbl.push_back(mk(1,1,0,0,0,0,4,1,0,32'h120, 0,0,0, 0,0,0, 4'b0110,1,32'h120,2,32'h14,0)); // WAW
        tbl.push_back(mk(1,1,0,0,2,1,0,0,0,32'h124, 1,2,1, 0,0,0, 4'b0110,1,32'h124,2,32'h14,0)); // rs2 RAW
        tbl.push_back(mk(1,1,0,1,4,0,0,1,0,32'h128, 1,4,1, 0,0,0, 4'b1001,1,32'h128,1,32'h10,0)); // x0 / unused
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,32'h12c, 1,0,0, 0,0,0, 4'b0011,1,32'h12c,1,32'h00,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,32'h130, 0,0,0, 0,0,0, 4'b0011,1,32'h130,0,32'h00,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,1,32'h104, 0,0,0, 0,0,0, 4'b1001,1,32'h104,0,32'h00,0)); // taken br
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0,32'h108, 0,0,0, 0,0,0, 4'b0110,0,32'h0,  1,32'h00,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0,32'h108, 1,0,0, 1,1,32'h40, 4'b0110,0,32'h0,1,32'h00,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0,32'h108, 0,0,0, 0,0,0, 4'b0011,1,32'h40, 0,32'h00,0)); // REDIRECT
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0,32'h44,  0,0,0, 0,0,0, 4'b1001,1,32'h44, 0,32'h00,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,32'h48,  1,0,0, 0,0,0, 4'b0011,1,32'h48, 1,32'h00,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,1,32'h104, 0,0,0, 0,0,0, 4'b1001,1,32'h104,0,32'h00,0)); // not taken
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0,32'h108, 0,0,0, 1,0,32'h40, 4'b0110,0,32'h0,1,32'h00,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0,32'h108, 0,0,0, 0,0,0, 4'b0011,1,32'h104,1,32'h00,0)); // REDIRECT
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,32'h108, 1,0,0, 0,0,0, 4'b0011,1,32'h108,1,32'h00,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,32'h10c, 1,0,0, 0,0,0, 4'b0011,1,32'h10c,0,32'h00,0)); // bad retire
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,32'h10c, 0,0,0, 0,0,0, 4'b0011,1,32'h10c,0,32'h00,1));

        #1 rst_n = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("v%0d issue/stall/bubble/pc_we", i), {28'd0, issue, stall_fd, bubble_de, pc_we}, {28'd0, e.isbw});
            if (e.chkpc) chk($sformatf("v%0d pc_next", i), pc_next, e.npc);
            chk($sformatf("v%0d inflight", i), {29'd0, inflight_o}, {29'd0, e.f});
            chk($sformatf("v%0d busy", i), busy_o, e.busy);
            chk($sformatf("v%0d err", i), {31'd0, err_o}, {31'd0, e.e});
        end

        // Branch in flight, then asynchronous reset in the middle of BR_WAIT.
        @(posedge clk); #1;
        d_valid = 1'b1; d_branch = 1'b1; d_rd = '0; d_regWrite = 1'b0; pc_plus4 = 32'h300;
        wb_valid = 1'b0; br_resolved = 1'b0;
        @(negedge clk);
        chk("mid br issue", {31'd0, issue}, 32'd1);
        @(posedge clk); #1;
        d_branch = 1'b0;
        @(negedge clk);
        chk("mid br_wait pc_we", {31'd0, pc_we}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async rst stall/pc_we", {30'd0, stall_fd, pc_we}, 32'd3);
        chk("async rst pc_next", pc_next, 32'h0);
        chk("async rst err", {31'd0, err_o}, 32'd0);
        chk("async rst inflight", {29'd0, inflight_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; d_valid = 1'b0;
        @(negedge clk);
        chk("boot after rst issue/stall/bubble/pc_we", {28'd0, issue, stall_fd, bubble_de, pc_we}, 32'd7);
        @(posedge clk); #1;
        br_resolved = 1'b1; br_taken = 1'b1; br_target = 32'h80;
        @(negedge clk);
        chk("run stray br stall", {31'd0, stall_fd}, 32'd0);
        chk("run stray br err before", {31'd0, err_o}, 32'd0);
        @(posedge clk); #1;
        br_resolved = 1'b0; br_taken = 1'b0; d_valid = 1'b1; pc_plus4 = 32'h500;
        @(negedge clk);
        chk("stray br err set", {31'd0, err_o}, 32'd1);
        chk("stray br still RUN issue", {31'd0, issue}, 32'd1);
        chk("stray br still RUN pc_next", pc_next, 32'h500);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
